// File: rtl/fmul_72bit_arbiter.sv
`default_nettype none
// fmul_72bit_arbiter: round-robin sharing of one fmul_72bit between two requesters, with an
// in-order owner tag FIFO routing results back. Optional macro FMUL_ARB_ERR_EN adds sticky oERR.
module fmul_72bit_arbiter #(
  parameter int P_TAG_DEPTH   = 8,
  parameter int P_TAG_DEPTH_N = 3
) (
  input  logic        iCLOCK,
  input  logic        inRESET,
  input  logic        iRESET_SYNC,
  input  logic        iREQ0,
  output logic        oBUSY0,
  input  logic [71:0] iA0,
  input  logic [71:0] iB0,
  input  logic        iREQ1,
  output logic        oBUSY1,
  input  logic [71:0] iA1,
  input  logic [71:0] iB1,
  output logic        oVALID0,
  input  logic        iBUSY0,
  output logic [71:0] oDATA0,
  output logic        oVALID1,
  input  logic        iBUSY1,
  output logic [71:0] oDATA1,
  output logic        oMUL_REQ,
  input  logic        iMUL_BUSY,
  output logic [71:0] oMUL_A,
  output logic [71:0] oMUL_B,
  input  logic        iMUL_VALID,
  output logic        oMUL_BUSY,
  input  logic [71:0] iMUL_DATA
`ifdef FMUL_ARB_ERR_EN
  ,
  output logic        oERR
`endif
);

  localparam logic [P_TAG_DEPTH_N:0] FULL_COUNT = (P_TAG_DEPTH_N+1)'(P_TAG_DEPTH);

  logic                     rr;
  logic [P_TAG_DEPTH-1:0]   tags;
  logic [P_TAG_DEPTH_N-1:0] wr_ptr;
  logic [P_TAG_DEPTH_N-1:0] rd_ptr;
  logic [P_TAG_DEPTH_N:0]   count;

  logic grant_valid;
  logic grant_port;
  logic full;
  logic empty;
  logic accept;
  logic head;
  logic head_busy;
  logic route;
  logic pop;

  // With a single requester it wins outright; rr only breaks ties.
  assign grant_valid = iREQ0 | iREQ1;
  assign grant_port  = (iREQ0 & iREQ1) ? rr : iREQ1;
  assign full        = (count == FULL_COUNT);
  assign empty       = (count == '0);

  assign oMUL_REQ = grant_valid & ~full & ~iRESET_SYNC;
  assign oMUL_A   = grant_port ? iA1 : iA0;
  assign oMUL_B   = grant_port ? iB1 : iB0;
  assign accept   = oMUL_REQ & ~iMUL_BUSY;
  assign oBUSY0   = ~(accept & ~grant_port);
  assign oBUSY1   = ~(accept & grant_port);

  // Results with no recorded owner are swallowed: not routed, not back-pressured.
  assign head      = tags[rd_ptr];
  assign head_busy = head ? iBUSY1 : iBUSY0;
  assign route     = ~empty & ~iRESET_SYNC;
  assign oVALID0   = route & iMUL_VALID & ~head;
  assign oVALID1   = route & iMUL_VALID & head;
  assign oMUL_BUSY = route & head_busy;
  assign pop       = route & iMUL_VALID & ~head_busy;
  assign oDATA0    = iMUL_DATA;
  assign oDATA1    = iMUL_DATA;

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      rr     <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (iRESET_SYNC) begin
      rr     <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (accept) begin
        wr_ptr <= wr_ptr + 1'b1;
        rr     <= ~grant_port;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({accept, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Tag storage needs no reset: entries are only read once count covers them.
  always_ff @(posedge iCLOCK) begin
    if (accept) begin
      tags[wr_ptr] <= grant_port;
    end
  end

`ifdef FMUL_ARB_ERR_EN
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      oERR <= 1'b0;
    end else if (iRESET_SYNC) begin
      oERR <= 1'b0;
    end else if (iMUL_VALID && empty) begin
      oERR <= 1'b1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_fmul_72bit_arbiter.sv
`default_nettype none
// tb_fmul_72bit_arbiter: directed table plus hand sequences; the bench plays the fmul_72bit role.
module tb_fmul_72bit_arbiter;

  logic        iCLOCK = 1'b0;
  logic        inRESET;
  logic        iRESET_SYNC;
  logic        iREQ0, iREQ1;
  logic        oBUSY0, oBUSY1;
  logic [71:0] iA0, iB0, iA1, iB1;
  logic        oVALID0, oVALID1;
  logic        iBUSY0, iBUSY1;
  logic [71:0] oDATA0, oDATA1;
  logic        oMUL_REQ;
  logic        iMUL_BUSY;
  logic [71:0] oMUL_A, oMUL_B;
  logic        iMUL_VALID;
  logic        oMUL_BUSY;
  logic [71:0] iMUL_DATA;
`ifdef FMUL_ARB_ERR_EN
  logic        oERR;
`endif

  int checks   = 0;
  int failures = 0;

  localparam logic [71:0] ONE  = 72'h3ff000000000000000;
  localparam logic [71:0] TWO  = 72'h400000000000000000;
  localparam logic [71:0] HALF = 72'h3fe000000000000000;

  fmul_72bit_arbiter #(.P_TAG_DEPTH(8), .P_TAG_DEPTH_N(3)) dut (
    .iCLOCK(iCLOCK), .inRESET(inRESET), .iRESET_SYNC(iRESET_SYNC),
    .iREQ0(iREQ0), .oBUSY0(oBUSY0), .iA0(iA0), .iB0(iB0),
    .iREQ1(iREQ1), .oBUSY1(oBUSY1), .iA1(iA1), .iB1(iB1),
    .oVALID0(oVALID0), .iBUSY0(iBUSY0), .oDATA0(oDATA0),
    .oVALID1(oVALID1), .iBUSY1(iBUSY1), .oDATA1(oDATA1),
    .oMUL_REQ(oMUL_REQ), .iMUL_BUSY(iMUL_BUSY), .oMUL_A(oMUL_A), .oMUL_B(oMUL_B),
    .iMUL_VALID(iMUL_VALID), .oMUL_BUSY(oMUL_BUSY), .iMUL_DATA(iMUL_DATA)
`ifdef FMUL_ARB_ERR_EN
    , .oERR(oERR)
`endif
  );

  always #5 iCLOCK = ~iCLOCK;

  typedef struct {
    logic r0, r1, mb;
    logic e_req, e_b0, e_b1, e_sel;
  } vec_t;

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    iREQ0 = 0; iREQ1 = 0; iBUSY0 = 0; iBUSY1 = 0; iMUL_BUSY = 0; iMUL_VALID = 0;
    iA0 = '0; iB0 = '0; iA1 = '0; iB1 = '0; iMUL_DATA = '0;
  endtask

  // Drive happens right after a falling edge; one rising edge passes per call.
  task automatic next_cycle();
    @(negedge iCLOCK);
  endtask

  task automatic sync_reset();
    clear_inputs();
    iRESET_SYNC = 1;
    next_cycle();
    iRESET_SYNC = 0;
  endtask

  task automatic issue(input logic port, input logic [71:0] a, input logic [71:0] b);
    iREQ0 = ~port; iREQ1 = port;
    if (port) begin iA1 = a; iB1 = b; end else begin iA0 = a; iB0 = b; end
    #1;
    chk(port ? "issue_busy1" : "issue_busy0", port ? oBUSY1 : oBUSY0, 0);
    next_cycle();
    iREQ0 = 0; iREQ1 = 0;
  endtask

  vec_t vecs[11];
  int   g0, g1;
  logic exp_port;

  initial begin
    vecs[0]  = '{r0:0, r1:0, mb:0, e_req:0, e_b0:1, e_b1:1, e_sel:0};
    vecs[1]  = '{r0:1, r1:0, mb:1, e_req:1, e_b0:1, e_b1:1, e_sel:0};
    vecs[2]  = '{r0:0, r1:1, mb:1, e_req:1, e_b0:1, e_b1:1, e_sel:1};
    vecs[3]  = '{r0:1, r1:1, mb:1, e_req:1, e_b0:1, e_b1:1, e_sel:0};
    vecs[4]  = '{r0:1, r1:1, mb:0, e_req:1, e_b0:0, e_b1:1, e_sel:0};
    vecs[5]  = '{r0:1, r1:1, mb:1, e_req:1, e_b0:1, e_b1:1, e_sel:1};
    vecs[6]  = '{r0:1, r1:1, mb:0, e_req:1, e_b0:1, e_b1:0, e_sel:1};
    vecs[7]  = '{r0:0, r1:1, mb:0, e_req:1, e_b0:1, e_b1:0, e_sel:1};
    vecs[8]  = '{r0:1, r1:1, mb:0, e_req:1, e_b0:0, e_b1:1, e_sel:0};
    vecs[9]  = '{r0:1, r1:0, mb:0, e_req:1, e_b0:0, e_b1:1, e_sel:0};
    vecs[10] = '{r0:1, r1:1, mb:1, e_req:1, e_b0:1, e_b1:1, e_sel:1};

    clear_inputs();
    iRESET_SYNC = 0;
    inRESET = 0;
    #22;
    inRESET = 1;
    next_cycle();

    // Reset state
    #1;
    chk("rst_mul_req", oMUL_REQ, 0);
    chk("rst_busy0", oBUSY0, 1);
    chk("rst_busy1", oBUSY1, 1);
    chk("rst_mul_busy", oMUL_BUSY, 0);
    chk("rst_valid0", oVALID0, 0);
`ifdef FMUL_ARB_ERR_EN
    chk("rst_err", oERR, 0);
`endif

    // Arbitration table
    for (int i = 0; i < 11; i++) begin
      next_cycle();
      iREQ0 = vecs[i].r0; iREQ1 = vecs[i].r1; iMUL_BUSY = vecs[i].mb;
      iA0 = 72'h100 + 72'(i); iB0 = 72'h200 + 72'(i);
      iA1 = 72'h300 + 72'(i); iB1 = 72'h400 + 72'(i);
      #1;
      chk($sformatf("v%0d_mul_req", i), oMUL_REQ, vecs[i].e_req);
      chk($sformatf("v%0d_busy0", i), oBUSY0, vecs[i].e_b0);
      chk($sformatf("v%0d_busy1", i), oBUSY1, vecs[i].e_b1);
      chk($sformatf("v%0d_mul_a", i), oMUL_A, vecs[i].e_sel ? iA1 : iA0);
      chk($sformatf("v%0d_mul_b", i), oMUL_B, vecs[i].e_sel ? iB1 : iB0);
      chk($sformatf("v%0d_valid", i), {oVALID0, oVALID1}, 2'b00);
    end
    next_cycle();
    sync_reset();

    // Port 0 alone
    iMUL_BUSY = 0;
    issue(0, ONE, TWO);
    next_cycle();
    iMUL_VALID = 1; iMUL_DATA = TWO;
    #1;
    chk("p0_valid0", oVALID0, 1);
    chk("p0_valid1", oVALID1, 0);
    chk("p0_data0", oDATA0, TWO);
    chk("p0_mul_busy", oMUL_BUSY, 0);
    next_cycle();
    iMUL_VALID = 0;

    // Simultaneous requests after reset: port 0 first
    sync_reset();
    iREQ0 = 1; iREQ1 = 1; iA0 = ONE; iB0 = ONE; iA1 = HALF; iB1 = TWO;
    #1;
    chk("both_first_busy0", oBUSY0, 0);
    chk("both_first_busy1", oBUSY1, 1);
    chk("both_first_a", oMUL_A, ONE);
    next_cycle();
    iREQ0 = 0;
    #1;
    chk("both_second_busy1", oBUSY1, 0);
    chk("both_second_a", oMUL_A, HALF);
    chk("both_second_b", oMUL_B, TWO);
    next_cycle();
    iREQ1 = 0;
    iMUL_VALID = 1; iMUL_DATA = ONE;
    #1;
    chk("both_res0_valid", {oVALID0, oVALID1}, 2'b10);
    chk("both_res0_data", oDATA0, ONE);
    next_cycle();
    #1;
    chk("both_res1_valid", {oVALID0, oVALID1}, 2'b01);
    chk("both_res1_data", oDATA1, ONE);
    next_cycle();
    iMUL_VALID = 0;

    // Back-pressure from port 0 holds port 1's result behind it
    sync_reset();
    issue(0, ONE, ONE);
    issue(1, ONE, TWO);
    iBUSY0 = 1; iMUL_VALID = 1; iMUL_DATA = 72'h0aa;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("bp_hold%0d_valid", k), {oVALID0, oVALID1}, 2'b10);
      chk($sformatf("bp_hold%0d_mul_busy", k), oMUL_BUSY, 1);
      next_cycle();
    end
    iBUSY0 = 0;
    #1;
    chk("bp_rel_mul_busy", oMUL_BUSY, 0);
    chk("bp_rel_valid0", {oVALID0, oVALID1}, 2'b10);
    next_cycle();
    iMUL_DATA = 72'h0bb;
    #1;
    chk("bp_second_valid1", {oVALID0, oVALID1}, 2'b01);
    chk("bp_second_data1", oDATA1, 72'h0bb);
    next_cycle();
    // Stray result on an empty FIFO is dropped
    #1;
    chk("empty_valid", {oVALID0, oVALID1}, 2'b00);
    chk("empty_mul_busy", oMUL_BUSY, 0);
    next_cycle();
    iMUL_VALID = 0;
`ifdef FMUL_ARB_ERR_EN
    #1;
    chk("empty_err", oERR, 1);
`endif

    // Full FIFO
    sync_reset();
    iBUSY0 = 1;
    for (int k = 0; k < 8; k++) issue(0, 72'(k), 72'(k));
    iREQ0 = 1; iA0 = 72'h99;
    #1;
    chk("full_busy0", oBUSY0, 1);
    chk("full_mul_req", oMUL_REQ, 0);
    next_cycle();
    iMUL_VALID = 1; iBUSY0 = 0;
    #1;
    chk("full_pop_mul_req", oMUL_REQ, 0);
    chk("full_pop_busy0", oBUSY0, 1);
    chk("full_pop_valid0", oVALID0, 1);
    next_cycle();
    iMUL_VALID = 0;
    #1;
    chk("after_drain_mul_req", oMUL_REQ, 1);
    chk("after_drain_busy0", oBUSY0, 0);
    next_cycle();
    iREQ0 = 0;

    // Synchronous reset with operations in flight
    sync_reset();
    issue(0, ONE, ONE);
    issue(1, ONE, ONE);
    issue(0, ONE, ONE);
    iRESET_SYNC = 1; iREQ0 = 1; iMUL_VALID = 1;
    #1;
    chk("srst_busy0", oBUSY0, 1);
    chk("srst_mul_req", oMUL_REQ, 0);
    chk("srst_valid", {oVALID0, oVALID1}, 2'b00);
    chk("srst_mul_busy", oMUL_BUSY, 0);
    next_cycle();
    iRESET_SYNC = 0; iREQ0 = 0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("stray%0d_valid", k), {oVALID0, oVALID1}, 2'b00);
      chk($sformatf("stray%0d_mul_busy", k), oMUL_BUSY, 0);
      next_cycle();
    end
    iMUL_VALID = 0;
`ifdef FMUL_ARB_ERR_EN
    #1;
    chk("stray_err", oERR, 1);
`endif

    // Fairness: results drained each cycle so the FIFO never fills
    sync_reset();
`ifdef FMUL_ARB_ERR_EN
    #1;
    chk("err_cleared", oERR, 0);
`endif
    g0 = 0; g1 = 0;
    iREQ0 = 1; iREQ1 = 1; iMUL_VALID = 1;
    for (int k = 0; k < 10; k++) begin
      exp_port = k[0];
      #1;
      chk($sformatf("fair%0d_grant", k), {oBUSY0, oBUSY1}, exp_port ? 2'b10 : 2'b01);
      if (!oBUSY0) g0++;
      if (!oBUSY1) g1++;
      next_cycle();
    end
    iREQ0 = 0; iREQ1 = 0; iMUL_VALID = 0;
    chk("fair_count0", 72'(g0), 72'd5);
    chk("fair_count1", 72'(g1), 72'd5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
